// File: rtl/bigboom_pkg.sv
// Shared constants for the bigboom ALU: data width and opcode encodings.
package bigboom_pkg;

   localparam int DATA_W = 8;

   localparam logic [2:0] OP_ADD = 3'b000;
   localparam logic [2:0] OP_SUB = 3'b001;
   localparam logic [2:0] OP_AND = 3'b010;
   localparam logic [2:0] OP_OR  = 3'b011;
   localparam logic [2:0] OP_XOR = 3'b100;
   localparam logic [2:0] OP_NOT = 3'b101;
   localparam logic [2:0] OP_SHL = 3'b110;
   localparam logic [2:0] OP_SHR = 3'b111;

endpackage

// File: rtl/bigboom_core.sv
// Combinational ALU datapath: (a, b, s) -> next result and carry/borrow/shift-out bit.
module bigboom_core
   import bigboom_pkg::*;
(
   input  logic [DATA_W-1:0] a,
   input  logic [DATA_W-1:0] b,
   input  logic [2:0]        s,
   output logic [DATA_W-1:0] res_d,
   output logic              carry_d
);

   logic [DATA_W:0] sum;
   logic [DATA_W:0] diff;

   // Zero-extended to 9 bits so bit 8 is the carry for ADD and the borrow for SUB.
   assign sum  = {1'b0, a} + {1'b0, b};
   assign diff = {1'b0, a} - {1'b0, b};

   always_comb begin
      res_d   = '0;
      carry_d = 1'b0;
      case (s)
         OP_ADD: {carry_d, res_d} = sum;
         OP_SUB: {carry_d, res_d} = diff;
         OP_AND: res_d = a & b;
         OP_OR:  res_d = a | b;
         OP_XOR: res_d = a ^ b;
         OP_NOT: res_d = ~a;
         OP_SHL: {carry_d, res_d} = {a, 1'b0};
         OP_SHR: {res_d, carry_d} = {1'b0, a};
         default: begin
            res_d   = '0;
            carry_d = 1'b0;
         end
      endcase
   end

endmodule

// File: rtl/bigboom_alu.sv
// 8-bit, 8-function ALU; one-cycle latency, outputs registered with async active-low reset.
module bigboom_alu
   import bigboom_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic [DATA_W-1:0] a,
   input  logic [DATA_W-1:0] b,
   input  logic [2:0]        s,
   output logic [DATA_W-1:0] result,
   output logic              carry
);

   logic [DATA_W-1:0] res_d;
   logic              carry_d;

   bigboom_core u_core (
      .a       (a),
      .b       (b),
      .s       (s),
      .res_d   (res_d),
      .carry_d (carry_d)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         result <= '0;
         carry  <= 1'b0;
      end else begin
         result <= res_d;
         carry  <= carry_d;
      end
   end

endmodule

// File: tb/tb_bigboom_alu.sv
// Self-checking bench for bigboom_alu: vector table, reset corners, back-to-back and random ops.
module tb_bigboom_alu;
   import bigboom_pkg::*;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [7:0] a = 8'h00;
   logic [7:0] b = 8'h00;
   logic [2:0] s = 3'b000;
   logic [7:0] result;
   logic       carry;

   int checks = 0;
   int errors = 0;

   typedef struct packed {
      logic [7:0] r;
      logic       c;
   } exp_t;

   typedef struct packed {
      logic [7:0] a;
      logic [7:0] b;
      logic [2:0] s;
      logic [7:0] r;
      logic       c;
   } vec_t;

   exp_t sb[$];

   bigboom_alu dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .a      (a),
      .b      (b),
      .s      (s),
      .result (result),
      .carry  (carry)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL timeout: simulation did not finish, got none, required completion");
      $fatal(1, "timeout");
   end

   function automatic exp_t model(input logic [7:0] xa, input logic [7:0] xb, input logic [2:0] xs);
      logic [8:0] w;
      exp_t e;
      w = 9'h000;
      case (xs)
         3'd0: w = xa + xb;
         3'd1: w = {1'b0, xa} - {1'b0, xb};
         3'd2: w = {1'b0, xa & xb};
         3'd3: w = {1'b0, xa | xb};
         3'd4: w = {1'b0, xa ^ xb};
         3'd5: w = {1'b0, ~xa};
         3'd6: w = {xa[7], xa[6:0], 1'b0};
         default: w = {xa[0], 1'b0, xa[7:1]};
      endcase
      e.r = w[7:0];
      e.c = w[8];
      return e;
   endfunction

   task automatic chk(input string name, input logic [7:0] ar, input logic ac,
                      input logic [7:0] er, input logic ec);
      checks++;
      if (ar !== er || ac !== ec) begin
         errors++;
         $display("FAIL %s: got result=%02h carry=%b, required result=%02h carry=%b",
                  name, ar, ac, er, ec);
      end
   endtask

   // Drive one op at the falling edge, queue its expectation, compare after the next rising edge.
   task automatic drive_exp(input string name, input logic [7:0] xa, input logic [7:0] xb,
                            input logic [2:0] xs, input exp_t e);
      exp_t got;
      @(negedge clk);
      a = xa; b = xb; s = xs;
      sb.push_back(e);
      @(posedge clk);
      #1;
      if (sb.size() == 0) begin
         checks++;
         errors++;
         $display("FAIL %s: scoreboard empty, got result=%02h, required an entry", name, result);
      end else begin
         got = sb.pop_front();
         chk(name, result, carry, got.r, got.c);
      end
   endtask

   task automatic drive(input string name, input logic [7:0] xa, input logic [7:0] xb,
                        input logic [2:0] xs);
      drive_exp(name, xa, xb, xs, model(xa, xb, xs));
   endtask

   vec_t vecs[13];

   initial begin
      vecs[0]  = '{8'h62, 8'h2D, OP_ADD, 8'h8F, 1'b0};
      vecs[1]  = '{8'h62, 8'h2D, OP_SUB, 8'h35, 1'b0};
      vecs[2]  = '{8'h62, 8'h2D, OP_AND, 8'h20, 1'b0};
      vecs[3]  = '{8'h62, 8'h2D, OP_OR,  8'h6F, 1'b0};
      vecs[4]  = '{8'h62, 8'h2D, OP_XOR, 8'h4F, 1'b0};
      vecs[5]  = '{8'h62, 8'h2D, OP_NOT, 8'h9D, 1'b0};
      vecs[6]  = '{8'h62, 8'h2D, OP_SHL, 8'hC4, 1'b0};
      vecs[7]  = '{8'h62, 8'h2D, OP_SHR, 8'h31, 1'b0};
      vecs[8]  = '{8'hFF, 8'h01, OP_ADD, 8'h00, 1'b1};
      vecs[9]  = '{8'h00, 8'h01, OP_SUB, 8'hFF, 1'b1};
      vecs[10] = '{8'h80, 8'h00, OP_SHL, 8'h00, 1'b1};
      vecs[11] = '{8'h01, 8'h00, OP_SHR, 8'h00, 1'b1};
      vecs[12] = '{8'hFE, 8'h00, OP_SHR, 8'h7F, 1'b0};

      // Reset held from time 0 with inputs that would give a nonzero result if clocked.
      a = 8'h0F; b = 8'h00; s = OP_NOT;
      #3;
      chk("reset_initial", result, carry, 8'h00, 1'b0);
      repeat (2) @(posedge clk);
      #1;
      chk("reset_hold", result, carry, 8'h00, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      chk("first_after_release", result, carry, 8'hF0, 1'b0);

      for (int i = 0; i < 13; i++)
         drive_exp($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].s,
                   '{vecs[i].r, vecs[i].c});

      // Back-to-back opcode changes with no idle cycle.
      for (int i = 0; i < 16; i++)
         drive($sformatf("b2b%0d", i), 8'hA5 + 8'(i), 8'h5A - 8'(i), 3'(i));

      // Mid-cycle reset: outputs clear at once and the pending op is dropped.
      drive("pre_reset", 8'h10, 8'h20, OP_ADD);
      #2;
      a = 8'hFF; b = 8'hFF; s = OP_ADD;
      rst_n = 1'b0;
      #1;
      chk("reset_midcycle", result, carry, 8'h00, 1'b0);
      repeat (2) @(posedge clk);
      #1;
      chk("reset_mid_hold", result, carry, 8'h00, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      chk("after_mid_release", result, carry, 8'hFE, 1'b1);

      for (int i = 0; i < 1000; i++)
         drive("rand", 8'($urandom), 8'($urandom), 3'($urandom_range(0, 7)));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
